etc_lane_reporter: RTL and testbench

//  Multi-lane successor to the single-lane ETC speed-reporting path. Captures speed results from
//  N_LANES non-stop ETC lanes and arbitrates round-robin. Frames each result as a 5-byte

---
 rtl/etc_lane_reporter.sv | 235 +++++++++++++++++++++++
 tb/tb_etc_lane_reporter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etc_lane_reporter.sv
// Multi-lane ETC speed reporter: per-lane capture, round-robin arbiter, 5-byte packet framer,
// byte FIFO and UART transmitter with optional parity.

module etc_lane_capture #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         done_i,
  input  logic         en_i,
  input  logic         grant_i,
  input  logic [W-1:0] speed_i,
  output logic         pend_o,
  output logic [W-1:0] speed_o,
  output logic         ovr_o
);
  logic         pend_q, ovr_q;
  logic [W-1:0] spd_q;

  // A new result on the granted lane re-arms pending without counting as an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
      spd_q  <= '0;
    end else if (done_i && en_i) begin
      spd_q  <= speed_i;
      pend_q <= 1'b1;
      if (pend_q && !grant_i) ovr_q <= 1'b1;
    end else if (grant_i) begin
      pend_q <= 1'b0;
    end
  end

  assign pend_o  = pend_q;
  assign speed_o = spd_q;
  assign ovr_o   = ovr_q;
endmodule

module etc_lane_reporter #(
  parameter int N_LANES      = 4,
  parameter int WIDTH_SPEED  = 14,
  parameter int DEPTH        = 16,
  parameter int SYS_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = SYS_FREQ / BAUD_RATE,
  parameter int PARITY       = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [N_LANES-1:0]               lane_done,
  input  logic [N_LANES*WIDTH_SPEED-1:0]   lane_speed,
  output logic                             serial_data_out,
  output logic                             tx_busy,
  output logic [N_LANES-1:0]               overrun,
  output logic [$clog2(DEPTH):0]           fifo_level
);
  localparam int LW  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] CNT_END = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {F_IDLE, F_HDR, F_LANE, F_SPH, F_SPL, F_CKS} fr_e;
  typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_PAR, U_STOP} tx_e;

  logic [N_LANES-1:0]                  pend, gnt_vec;
  logic [N_LANES-1:0][WIDTH_SPEED-1:0] spd;
  logic                                hit, grant, rd_en;
  logic [LW-1:0]                       gnt_id, last_q, lane_q;
  logic [15:0]                         spd16_q;
  fr_e                                 fr_q;
  logic                                wen_q;
  logic [7:0]                          wdat_q;
  logic [7:0]                          mem [DEPTH];
  logic [AW-1:0]                       wp_q, rp_q;
  logic [AW:0]                         lvl_q;
  logic [7:0]                          head;
  tx_e                                 tx_q;
  logic [BW-1:0]                       cnt_q;
  logic [2:0]                          bit_q;
  logic [7:0]                          sh_q;
  logic                                par_q, ser_q, busy_q;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    etc_lane_capture #(.W(WIDTH_SPEED)) u_cap (
      .clk     (clk),
      .reset_n (reset_n),
      .done_i  (lane_done[i]),
      .en_i    (enable),
      .grant_i (gnt_vec[i]),
      .speed_i (lane_speed[i*WIDTH_SPEED +: WIDTH_SPEED]),
      .pend_o  (pend[i]),
      .speed_o (spd[i]),
      .ovr_o   (overrun[i])
    );
  end

  // Round-robin scan starting one past the last granted lane.
  always_comb begin
    int idx;
    idx    = 0;
    hit    = 1'b0;
    gnt_id = '0;
    for (int k = 1; k <= N_LANES; k++) begin
      idx = (int'(last_q) + k) % N_LANES;
      if (!hit && pend[idx]) begin
        hit    = 1'b1;
        gnt_id = LW'(idx);
      end
    end
  end

  assign grant = (fr_q == F_IDLE) && hit && (int'(lvl_q) <= DEPTH - 5);

  always_comb begin
    gnt_vec = '0;
    if (grant) gnt_vec[gnt_id] = 1'b1;
  end

  // Framer: the byte written during each state is registered on entry to that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fr_q    <= F_IDLE;
      last_q  <= LW'(N_LANES - 1);
      lane_q  <= '0;
      spd16_q <= '0;
      wen_q   <= 1'b0;
      wdat_q  <= '0;
    end else begin
      case (fr_q)
        F_IDLE: if (grant) begin
          fr_q    <= F_HDR;
          last_q  <= gnt_id;
          lane_q  <= gnt_id;
          spd16_q <= 16'(spd[gnt_id]);
          wen_q   <= 1'b1;
          wdat_q  <= 8'hA5;
        end
        F_HDR:  begin fr_q <= F_LANE; wdat_q <= 8'(lane_q);       end
        F_LANE: begin fr_q <= F_SPH;  wdat_q <= spd16_q[15:8];    end
        F_SPH:  begin fr_q <= F_SPL;  wdat_q <= spd16_q[7:0];     end
        F_SPL:  begin
          fr_q   <= F_CKS;
          wdat_q <= 8'(lane_q) ^ spd16_q[15:8] ^ spd16_q[7:0];
        end
        default: begin fr_q <= F_IDLE; wen_q <= 1'b0; end
      endcase
    end
  end

  assign head  = mem[rp_q];
  assign rd_en = (tx_q == U_IDLE) && (lvl_q != '0);

  always_ff @(posedge clk) begin
    if (wen_q) mem[wp_q] <= wdat_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (wen_q) wp_q <= wp_q + 1'b1;
      if (rd_en) rp_q <= rp_q + 1'b1;
      case ({wen_q, rd_en})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_q   <= U_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      ser_q  <= 1'b1;
      busy_q <= 1'b0;
    end else if (tx_q == U_IDLE) begin
      ser_q  <= 1'b1;
      busy_q <= 1'b0;
      if (rd_en) begin
        tx_q   <= U_START;
        sh_q   <= head;
        par_q  <= (PARITY == 2) ? ~^head : ^head;
        cnt_q  <= '0;
        ser_q  <= 1'b0;
        busy_q <= 1'b1;
      end
    end else if (cnt_q != CNT_END) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
      case (tx_q)
        U_START: begin
          tx_q  <= U_DATA;
          bit_q <= '0;
          ser_q <= sh_q[0];
          sh_q  <= sh_q >> 1;
        end
        U_DATA: begin
          if (bit_q != 3'd7) begin
            bit_q <= bit_q + 1'b1;
            ser_q <= sh_q[0];
            sh_q  <= sh_q >> 1;
          end else if (PARITY != 0) begin
            tx_q  <= U_PAR;
            ser_q <= par_q;
          end else begin
            tx_q  <= U_STOP;
            ser_q <= 1'b1;
          end
        end
        U_PAR: begin
          tx_q  <= U_STOP;
          ser_q <= 1'b1;
        end
        default: begin
          tx_q   <= U_IDLE;
          ser_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign serial_data_out = ser_q;
  assign tx_busy         = busy_q;
  assign fifo_level      = lvl_q;
endmodule

// File: tb/tb_etc_lane_reporter.sv
// Directed bench for etc_lane_reporter: one no-parity instance decoded by a line monitor,
// plus even- and odd-parity instances sharing the same stimulus.

module tb_etc_lane_reporter;
  localparam int NL = 4, WS = 14, DP = 16, SF = 1000000, BR = 100000;

  logic               clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
  logic [NL-1:0]      lane_done = '0;
  logic [NL*WS-1:0]   lane_speed = '0;
  logic [2:0]         ser, busy;
  logic [NL-1:0]      ovr0, ovr1, ovr2;
  logic [4:0]         lvl0, lvl1, lvl2;

  int total = 0, bad = 0;
  logic [7:0] rxq[$];
  int brun[3], blast[3];
  int peak;
  logic clr_pk = 1'b0;

  etc_lane_reporter #(.N_LANES(NL), .WIDTH_SPEED(WS), .DEPTH(DP), .SYS_FREQ(SF),
                      .BAUD_RATE(BR), .PARITY(0)) u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .lane_done(lane_done),
    .lane_speed(lane_speed), .serial_data_out(ser[0]), .tx_busy(busy[0]),
    .overrun(ovr0), .fifo_level(lvl0));
  etc_lane_reporter #(.N_LANES(NL), .WIDTH_SPEED(WS), .DEPTH(DP), .SYS_FREQ(SF),
                      .BAUD_RATE(BR), .PARITY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .lane_done(lane_done),
    .lane_speed(lane_speed), .serial_data_out(ser[1]), .tx_busy(busy[1]),
    .overrun(ovr1), .fifo_level(lvl1));
  etc_lane_reporter #(.N_LANES(NL), .WIDTH_SPEED(WS), .DEPTH(DP), .SYS_FREQ(SF),
                      .BAUD_RATE(BR), .PARITY(2)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .lane_done(lane_done),
    .lane_speed(lane_speed), .serial_data_out(ser[2]), .tx_busy(busy[2]),
    .overrun(ovr2), .fifo_level(lvl2));

  always #5 clk = ~clk;

  // Line monitor for the no-parity instance: 10 clocks per bit, sampled mid-bit.
  initial begin
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (ser[0] == 1'b0) begin
        repeat (5) @(negedge clk);
        if (ser[0] == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clk);
            b[i] = ser[0];
          end
          repeat (10) @(negedge clk);
          rxq.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (busy[d]) brun[d] <= brun[d] + 1;
      else begin
        if (brun[d] != 0) blast[d] <= brun[d];
        brun[d] <= 0;
      end
    end
    if (clr_pk) peak <= 0;
    else if (int'(lvl0) > peak) peak <= int'(lvl0);
  end

  task automatic set_spd(input int l, input logic [WS-1:0] v);
    lane_speed[l*WS +: WS] = v;
  endtask

  task automatic fire(input logic [NL-1:0] m);
    @(posedge clk); #1 lane_done = m;
    @(posedge clk); #1 lane_done = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    for (int c = 0; c < budget && rxq.size() < n; c++) @(negedge clk);
    ok = (rxq.size() >= n);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ser[0] !== 1'b1) begin bad++; $display("FAIL rst_ser got=%b exp=1", ser[0]); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy[0]); end
    total++; if (ovr0 !== 4'b0) begin bad++; $display("FAIL rst_ovr got=%b exp=0000", ovr0); end
    total++; if (lvl0 !== 5'd0) begin bad++; $display("FAIL rst_lvl got=%0d exp=0", lvl0); end
    reset_n = 1'b1;
    enable  = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp [5];
    int base;
    bit ok;
    exp = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h24};
    base = rxq.size();
    set_spd(2, 14'h1234);
    clr_pk = 1'b1; @(negedge clk); clr_pk = 1'b0;
    fire(4'b0100);
    wait_rx(base + 5, 800, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_rx_timeout got=%0d exp=%0d", rxq.size() - base, 5); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rxq.size() <= base + k || rxq[base + k] !== exp[k]) begin
        bad++; $display("FAIL single_byte%0d got=%h exp=%h", k, (rxq.size() > base + k) ? rxq[base + k] : 8'hxx, exp[k]);
      end
    end
    repeat (20) @(negedge clk);
    total++; if (blast[0] != 100) begin bad++; $display("FAIL single_char_len got=%0d exp=100", blast[0]); end
    total++; if (lvl0 !== 5'd0) begin bad++; $display("FAIL single_drain got=%0d exp=0", lvl0); end
    total++; if (peak < 4 || peak > 5) begin bad++; $display("FAIL single_peak got=%0d exp=4..5", peak); end
  endtask

  task automatic test_order();
    int base;
    bit ok;
    logic [7:0] ids3 [3];
    ids3 = '{8'h00, 8'h01, 8'h03};
    do_reset();
    base = rxq.size();
    set_spd(0, 14'h0011); set_spd(1, 14'h0022); set_spd(3, 14'h0033);
    fire(4'b1011);
    wait_rx(base + 15, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL order3_timeout got=%0d exp=15", rxq.size() - base); end
    for (int p = 0; p < 3; p++) begin
      total++;
      if (rxq.size() <= base + 5*p + 1 || rxq[base + 5*p + 1] !== ids3[p]) begin
        bad++; $display("FAIL order3_pkt%0d_lane got=%h exp=%h", p,
                        (rxq.size() > base + 5*p + 1) ? rxq[base + 5*p + 1] : 8'hxx, ids3[p]);
      end
    end
    base = rxq.size();
    for (int l = 0; l < 4; l++) set_spd(l, 14'h0100 + 14'(l));
    fire(4'b1111);
    wait_rx(base + 20, 2600, ok);
    total++; if (!ok) begin bad++; $display("FAIL order4_timeout got=%0d exp=20", rxq.size() - base); end
    for (int p = 0; p < 4; p++) begin
      total++;
      if (rxq.size() <= base + 5*p + 3 || rxq[base + 5*p + 1] !== 8'(p) || rxq[base + 5*p + 3] !== 8'(p)) begin
        bad++; $display("FAIL order4_pkt%0d got=lane %h lo %h exp=%0d", p,
                        (rxq.size() > base + 5*p + 1) ? rxq[base + 5*p + 1] : 8'hxx,
                        (rxq.size() > base + 5*p + 3) ? rxq[base + 5*p + 3] : 8'hxx, p);
      end
    end
  endtask

  task automatic test_overrun();
    int base;
    bit ok;
    logic [7:0] exp [5];
    exp = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h21};
    do_reset();
    base = rxq.size();
    set_spd(0, 14'h0100); set_spd(2, 14'h0200); set_spd(3, 14'h0300);
    fire(4'b1101);
    repeat (30) @(posedge clk);
    #1;
    total++; if (lvl0 < 5'd12) begin bad++; $display("FAIL ovr_fifo_full got=%0d exp>=12", lvl0); end
    set_spd(1, 14'h0010);
    fire(4'b0010);
    repeat (5) @(posedge clk);
    #1;
    total++; if (ovr0 !== 4'b0000) begin bad++; $display("FAIL ovr_first got=%b exp=0000", ovr0); end
    set_spd(1, 14'h0020);
    fire(4'b0010);
    total++; if (ovr0 !== 4'b0010) begin bad++; $display("FAIL ovr_second got=%b exp=0010", ovr0); end
    wait_rx(base + 20, 2600, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovr_timeout got=%0d exp=20", rxq.size() - base); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rxq.size() <= base + 15 + k || rxq[base + 15 + k] !== exp[k]) begin
        bad++; $display("FAIL ovr_byte%0d got=%h exp=%h", k,
                        (rxq.size() > base + 15 + k) ? rxq[base + 15 + k] : 8'hxx, exp[k]);
      end
    end
    repeat (300) @(negedge clk);
    total++; if (rxq.size() != base + 20) begin bad++; $display("FAIL ovr_extra_pkt got=%0d exp=20", rxq.size() - base); end
    total++; if (ovr0 !== 4'b0010) begin bad++; $display("FAIL ovr_sticky got=%b exp=0010", ovr0); end
    do_reset();
    total++; if (ovr0 !== 4'b0000) begin bad++; $display("FAIL ovr_clear got=%b exp=0000", ovr0); end
  endtask

  task automatic test_enable();
    int base;
    bit ok;
    logic [7:0] exp [5];
    exp = '{8'hA5, 8'h03, 8'h0A, 8'hBC, 8'hB5};
    base = rxq.size();
    enable = 1'b0;
    set_spd(0, 14'h0077);
    fire(4'b0001);
    fire(4'b0001);
    repeat (300) @(negedge clk);
    total++; if (rxq.size() != base) begin bad++; $display("FAIL en_off_pkts got=%0d exp=0", rxq.size() - base); end
    total++; if (ovr0 !== 4'b0000) begin bad++; $display("FAIL en_off_ovr got=%b exp=0000", ovr0); end
    total++; if (lvl0 !== 5'd0) begin bad++; $display("FAIL en_off_lvl got=%0d exp=0", lvl0); end
    enable = 1'b1;
    set_spd(3, 14'h0ABC);
    fire(4'b1000);
    enable = 1'b0;
    set_spd(0, 14'h0055);
    fire(4'b0001);
    repeat (40) @(posedge clk);
    #1 enable = 1'b1;
    wait_rx(base + 5, 800, ok);
    total++; if (!ok) begin bad++; $display("FAIL en_timeout got=%0d exp=5", rxq.size() - base); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rxq.size() <= base + k || rxq[base + k] !== exp[k]) begin
        bad++; $display("FAIL en_byte%0d got=%h exp=%h", k, (rxq.size() > base + k) ? rxq[base + k] : 8'hxx, exp[k]);
      end
    end
    repeat (600) @(negedge clk);
    total++; if (rxq.size() != base + 5) begin bad++; $display("FAIL en_extra_pkt got=%0d exp=5", rxq.size() - base); end
    total++; if (ovr0 !== 4'b0000) begin bad++; $display("FAIL en_ovr got=%b exp=0000", ovr0); end
  endtask

  task automatic test_parity();
    int rises;
    logic pb;
    logic [7:0] d1, d2;
    logic p1, p2, s1, s2;
    do_reset();
    set_spd(0, 14'h0007);
    fire(4'b0001);
    rises = 0;
    pb = busy[1];
    for (int c = 0; c < 1500 && rises < 4; c++) begin
      @(negedge clk);
      if (busy[1] && !pb) rises++;
      pb = busy[1];
    end
    total++; if (rises != 4) begin bad++; $display("FAIL par_timeout got=%0d exp=4", rises); end
    d1 = '0; d2 = '0;
    for (int i = 0; i < 8; i++) begin
      repeat ((i == 0) ? 15 : 10) @(negedge clk);
      d1[i] = ser[1]; d2[i] = ser[2];
    end
    repeat (10) @(negedge clk);
    p1 = ser[1]; p2 = ser[2];
    repeat (10) @(negedge clk);
    s1 = ser[1]; s2 = ser[2];
    total++; if (d1 !== 8'h07 || d2 !== 8'h07) begin bad++; $display("FAIL par_data got=%h/%h exp=07", d1, d2); end
    total++; if (p1 !== 1'b1) begin bad++; $display("FAIL par_even_bit got=%b exp=1", p1); end
    total++; if (p2 !== 1'b0) begin bad++; $display("FAIL par_odd_bit got=%b exp=0", p2); end
    total++; if (s1 !== 1'b1 || s2 !== 1'b1) begin bad++; $display("FAIL par_stop got=%b/%b exp=1", s1, s2); end
    repeat (20) @(negedge clk);
    total++; if (blast[1] != 110 || blast[2] != 110) begin
      bad++; $display("FAIL par_char_len got=%0d/%0d exp=110", blast[1], blast[2]);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    logic pb;
    logic [7:0] exp [5];
    exp = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h03};
    repeat (1200) @(negedge clk);
    set_spd(1, 14'h0055);
    fire(4'b0010);
    ok = 1'b0;
    pb = busy[0];
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = busy[0] && !pb;
      pb = busy[0];
    end
    total++; if (!ok) begin bad++; $display("FAIL mid_busy_timeout got=0 exp=1"); end
    repeat (25) @(negedge clk);
    total++; if (ser[0] !== 1'b0) begin bad++; $display("FAIL mid_line_low got=%b exp=0", ser[0]); end
    reset_n = 1'b0;
    #1;
    total++; if (ser[0] !== 1'b1) begin bad++; $display("FAIL mid_rst_ser got=%b exp=1", ser[0]); end
    total++; if (lvl0 !== 5'd0) begin bad++; $display("FAIL mid_rst_lvl got=%0d exp=0", lvl0); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy[0]); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (300) @(negedge clk);
    base = rxq.size();
    set_spd(2, 14'h0001);
    fire(4'b0100);
    wait_rx(base + 5, 800, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_after_timeout got=%0d exp=5", rxq.size() - base); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (rxq.size() <= base + k || rxq[base + k] !== exp[k]) begin
        bad++; $display("FAIL mid_byte%0d got=%h exp=%h", k, (rxq.size() > base + k) ? rxq[base + k] : 8'hxx, exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_overrun();
    test_enable();
    test_parity();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
